seg7_scan_decoder: RTL and testbench

- Observes a multiplexed, active-low 4-digit seven-segment bus (anodes plus cathodes), the same bus our adder and display blocks drive.
- Decodes each digit's segment pattern back to a 4-bit hex value.
- Commits a digit only after its pattern has been stable across several consecutive scans.
- Used on-chip and in benches as the receive end of the display interface, for self-checking of display drivers.

---
 rtl/seg7_pkg.sv | 60 ++++++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 135 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the active-low seven-segment display bus: segment bit
// positions, the hex glyph set and a pattern decoder.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high patterns, bit SEG_A in position 0.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry i is the glyph for hex value i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] val;
    } glyph_info_t;

    function automatic glyph_info_t seg7_decode(input logic [6:0] pattern);
        glyph_info_t info;
        info       = '0;
        info.blank = (pattern == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                info.legal = 1'b1;
                info.val   = 4'(i);
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of one active-high segment pattern to its hex value,
// flagging blank and illegal patterns.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic       blank,
    output logic [3:0] val
);

    glyph_info_t info;

    always_comb begin
        info  = seg7_decode(pattern);
        legal = info.legal;
        blank = info.blank;
        val   = info.val;
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed seven-segment bus: tracks per-digit pattern
// stability, commits decoded digits and flags completed frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   digit_val,
    output logic [DIGITS-1:0]     digit_err,
    output logic [DIGITS-1:0]     digit_blank,
    output logic                  frame_valid,
    output logic                  an_conflict
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

    logic [DIGITS-1:0] lows;
    logic              one_low;
    logic              multi_low;
    logic [IDX_W-1:0]  sel;
    logic [6:0]        pattern;

    logic [6:0]        cand [DIGITS];
    logic [CNT_W-1:0]  cnt  [DIGITS];
    logic [DIGITS-1:0] fresh;

    logic [6:0]        cur_cand;
    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              match;
    logic              at_limit;
    logic              commit;
    logic [DIGITS-1:0] commit_mask;
    logic              frame_done;

    logic              g_legal;
    logic              g_blank;
    logic [3:0]        g_val;

    assign lows    = ~an;
    assign pattern = ~seg;

    // Clearing the lowest set bit leaves a nonzero value only if two or more anodes are low.
    always_comb begin
        multi_low = (lows & (lows - DIGITS'(1))) != '0;
        one_low   = (lows != '0) && !multi_low;
        sel       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (lows[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    seg7_glyph_decode u_glyph_decode (
        .pattern (pattern),
        .legal   (g_legal),
        .blank   (g_blank),
        .val     (g_val)
    );

    // A saturated counter holding the same pattern must not re-commit.
    always_comb begin
        cur_cand    = cand[sel];
        cur_cnt     = cnt[sel];
        match       = (pattern == cur_cand);
        at_limit    = (cur_cnt == STABLE);
        next_cnt    = CNT_W'(1);
        if (match) begin
            next_cnt = at_limit ? cur_cnt : cur_cnt + CNT_W'(1);
        end
        commit      = one_low && !(match && at_limit) && (next_cnt == STABLE);
        commit_mask = '0;
        if (commit) begin
            commit_mask[sel] = 1'b1;
        end
        frame_done  = &fresh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
            end
        end else if (one_low) begin
            cand[sel] <= pattern;
            cnt[sel]  <= next_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val   <= '0;
            digit_err   <= '0;
            digit_blank <= '0;
        end else if (commit) begin
            if (g_legal) begin
                digit_val[4*int'(sel) +: 4] <= g_val;
                digit_err[sel]              <= 1'b0;
                digit_blank[sel]            <= 1'b0;
            end else if (g_blank) begin
                digit_val[4*int'(sel) +: 4] <= 4'h0;
                digit_err[sel]              <= 1'b0;
                digit_blank[sel]            <= 1'b1;
            end else begin
                digit_err[sel]              <= 1'b1;
                digit_blank[sel]            <= 1'b0;
            end
        end
    end

    // A commit landing on the clearing cycle starts the next frame's bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fresh       <= '0;
            frame_valid <= 1'b0;
            an_conflict <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            fresh       <= (frame_done ? '0 : fresh) | commit_mask;
            if (multi_low) begin
                an_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized and directed bench for seg7_scan_decoder against a run-length
// reference model of the display receive rules.
module tb_seg7_scan_decoder;

    localparam int STABLE_CNT = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digit_val;
    logic [3:0]  digit_err;
    logic [3:0]  digit_blank;
    logic        frame_valid;
    logic        an_conflict;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CNT(STABLE_CNT), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digit_val   (digit_val),
        .digit_err   (digit_err),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .an_conflict (an_conflict)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0] glyph_tab [16];

    // reference model state: last pattern seen per digit and its run length
    logic [15:0] m_val;
    logic [3:0]  m_err;
    logic [3:0]  m_blank;
    logic [3:0]  m_fresh;
    logic        m_fv;
    logic        m_conf;
    logic [6:0]  m_last [4];
    int          m_run  [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_val   = '0;
        m_err   = '0;
        m_blank = '0;
        m_fresh = '0;
        m_fv    = 1'b0;
        m_conf  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_last[i] = '0;
            m_run[i]  = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] a, input logic [6:0] p);
        logic [3:0] lows;
        logic [3:0] cmask;
        logic       done;
        int         d;
        int         code;
        lows  = ~a;
        cmask = '0;
        done  = (m_fresh == 4'hF);
        if ($countones(lows) == 1) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (lows[i]) d = i;
            if (p == m_last[d]) m_run[d]++;
            else begin
                m_last[d] = p;
                m_run[d]  = 1;
            end
            if (m_run[d] == STABLE_CNT) begin
                cmask[d] = 1'b1;
                code = -1;
                for (int k = 0; k < 16; k++) if (glyph_tab[k] == p) code = k;
                if (code >= 0) begin
                    m_val[4*d +: 4] = 4'(code);
                    m_err[d]   = 1'b0;
                    m_blank[d] = 1'b0;
                end else if (p == 7'h00) begin
                    m_val[4*d +: 4] = 4'h0;
                    m_err[d]   = 1'b0;
                    m_blank[d] = 1'b1;
                end else begin
                    m_err[d]   = 1'b1;
                    m_blank[d] = 1'b0;
                end
            end
        end else if ($countones(lows) > 1) begin
            m_conf = 1'b1;
        end
        m_fv    = done;
        m_fresh = (done ? 4'h0 : m_fresh) | cmask;
    endtask

    task automatic compare_all();
        check("digit_val",   32'(digit_val),   32'(m_val));
        check("digit_err",   32'(digit_err),   32'(m_err));
        check("digit_blank", 32'(digit_blank), 32'(m_blank));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("an_conflict", 32'(an_conflict), 32'(m_conf));
    endtask

    // driver: one bus sample per call, pattern given active-high
    task automatic drive(input logic [3:0] a, input logic [6:0] p);
        @(negedge clk);
        an  = a;
        seg = ~p;
        @(posedge clk);
        model_step(a, p);
        #1;
        compare_all();
    endtask

    task automatic drive_n(input logic [3:0] a, input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) drive(a, p);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(negedge clk);
        an    = 4'hF;
        rst_n = 1'b1;
    endtask

    int frame_pulses;

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst_n = 1'b1;
        an    = 4'hF;
        seg   = 7'h7F;
        model_clear();
        do_reset();
        drive(4'hF, 7'h00);

        // glyph 5 on digit 0
        drive_n(4'b1110, 7'h6D, 2);
        check("d0_before_commit", 32'(digit_val[3:0]), 32'h0);
        drive(4'b1110, 7'h6D);
        check("d0_five", 32'(digit_val[3:0]), 32'h5);
        check("d0_err", 32'(digit_err[0]), 32'h0);

        // 1,2,3,4 across digits, then a steady rescan
        frame_pulses = 0;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) begin
                drive(~(4'b0001 << d), glyph_tab[d+1]);
                if (frame_valid) frame_pulses++;
            end
        end
        drive(4'hF, 7'h00);
        if (frame_valid) frame_pulses++;
        drive(4'hF, 7'h00);
        if (frame_valid) frame_pulses++;
        check("val_4321", 32'(digit_val), 32'h4321);
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) begin
                drive(~(4'b0001 << d), glyph_tab[d+1]);
                if (frame_valid) frame_pulses++;
            end
        end
        check("one_frame_pulse", 32'(frame_pulses), 32'd1);

        // illegal pattern then A on digit 2
        drive_n(4'b1011, 7'h49, 3);
        check("d2_err", 32'(digit_err[2]), 32'h1);
        check("d2_val_kept", 32'(digit_val[11:8]), 32'h3);
        drive_n(4'b1011, 7'h77, 3);
        check("d2_err_clr", 32'(digit_err[2]), 32'h0);
        check("d2_val_a", 32'(digit_val[11:8]), 32'hA);

        // alternating 1/2 on digit 1 never commits
        for (int k = 0; k < 8; k++) drive(4'b1101, (k % 2 == 0) ? 7'h06 : 7'h5B);
        check("d1_held", 32'(digit_val[7:4]), 32'h2);

        // conflict mid-scan: counters untouched
        drive_n(4'b1110, 7'h07, 2);
        drive(4'b1100, 7'h7F);
        check("conflict_set", 32'(an_conflict), 32'h1);
        drive(4'b1110, 7'h07);
        check("commit_after_conflict", 32'(digit_val[3:0]), 32'h7);
        drive_n(4'hF, 7'h00, 2);
        check("conflict_sticky", 32'(an_conflict), 32'h1);

        // reset after 2 of 3 samples discards the partial run
        drive_n(4'b0111, 7'h6F, 2);
        do_reset();
        drive_n(4'b0111, 7'h6F, 2);
        check("no_commit_after_rst", 32'(digit_val[15:12]), 32'h0);
        drive(4'b0111, 7'h6F);
        check("commit_after_rst", 32'(digit_val[15:12]), 32'h9);

        // blank commit
        drive_n(4'b1101, 7'h00, 3);
        check("d1_blank", 32'(digit_blank[1]), 32'h1);

        // randomized scanning
        for (int it = 0; it < 300; it++) begin
            int r;
            int d;
            int len;
            logic [6:0] p;
            logic [3:0] a;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                a = 4'($urandom_range(0, 15));
                while ($countones(~a) < 2) a = 4'($urandom_range(0, 15));
                drive(a, 7'($urandom_range(0, 127)));
            end else if (r < 8) begin
                drive(4'hF, 7'($urandom_range(0, 127)));
            end else begin
                d   = $urandom_range(0, 3);
                len = $urandom_range(1, 5);
                r   = $urandom_range(0, 99);
                if (r < 70)      p = glyph_tab[$urandom_range(0, 15)];
                else if (r < 85) p = 7'h00;
                else             p = 7'($urandom_range(0, 127));
                drive_n(~(4'b0001 << d), p, len);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
